// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, exception flag positions, and the qNaN pattern builder.
// No logic; referenced by the divider and by the rounding helper.
// Port summary: none (package).
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rmode_e;

  // Bit positions inside the 5-bit {NV, DZ, OF, UF, NX} flag word.
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  // Canonical quiet NaN for any format up to 64 bits: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] qnan_bits(input int unsigned exp_w, input int unsigned man_w);
    qnan_bits = (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fpu_round.sv
// Rounding increment decision shared by the FPU datapaths.
// Latency: combinational. Backpressure: none.
// Ports: i_mode/i_sign/i_lsb/i_g/i_r/i_s in, o_inc = add one ulp to the truncated significand.
module fpu_round
  import fpu_pkg::*;
(
  input  rmode_e i_mode,
  input  logic   i_sign,
  input  logic   i_lsb,
  input  logic   i_g,
  input  logic   i_r,
  input  logic   i_s,
  output logic   o_inc
);

  logic w_any;
  assign w_any = i_g | i_r | i_s;

  always_comb begin
    o_inc = 1'b0;
    case (i_mode)
      RM_RTZ:  o_inc = 1'b0;
      RM_RDN:  o_inc = i_sign & w_any;
      RM_RUP:  o_inc = ~i_sign & w_any;
      RM_RMM:  o_inc = i_g;
      // RNE: above half rounds up, exact half rounds to even.
      default: o_inc = i_g & (i_r | i_s | i_lsb);
    endcase
  end

endmodule

// File: rtl/fpu_div_rm.sv
// IEEE-754 divider, restoring shift-subtract core, one quotient bit per cycle, five rounding modes.
// Latency: 3 edges for specials, MAN_W+11 for normal operands/result, +1 per subnormal-operand leading zero and per denormalising shift.
// Backpressure: none; i_valid is sampled only while idle, o_busy marks the occupied window, o_ready is a one-cycle pulse.
// Ports: i_clk, i_reset (sync, high), i_din1/i_din2 operands, i_rmode, i_valid; o_busy, o_result, o_flags {NV,DZ,OF,UF,NX}, o_ready.
module fpu_div_rm
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [EXP_W+MAN_W:0]     i_din1,
  input  logic [EXP_W+MAN_W:0]     i_din2,
  input  logic [2:0]               i_rmode,
  input  logic                     i_valid,
  output logic                     o_busy,
  output logic [EXP_W+MAN_W:0]     o_result,
  output logic [4:0]               o_flags,
  output logic                     o_ready
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW   = EXP_W + 3;   // signed unbiased exponent width
  localparam int QW   = MAN_W + 4;   // hidden + fraction + guard + round + sticky bit
  localparam int RW   = MAN_W + 3;   // remainder stays below twice the divisor
  localparam int CW   = $clog2(MAN_W + 5);
  localparam logic signed [EW-1:0] EBIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN  = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] EONE  = EW'(1);
  localparam logic [63:0]          QNAN64 = qnan_bits(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN   = QNAN64[W-1:0];

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_CLASSIFY, S_NORM_A, S_NORM_B,
    S_DIVIDE, S_POST_NORM, S_DENORM, S_ROUND, S_PACK
  } state_e;

  state_e                 r_state;
  logic [W-1:0]           r_a, r_b, r_res_n, r_result;
  rmode_e                 r_rm;
  logic                   r_sa, r_sb, r_sticky, r_tiny, r_busy, r_ready;
  logic [EXP_W-1:0]       r_ea, r_eb;
  logic [MAN_W-1:0]       r_fa, r_fb;
  logic [MAN_W:0]         r_ma, r_mb;
  logic signed [EW-1:0]   r_xa, r_xb, r_xq;
  logic [RW-1:0]          r_rem;
  logic [QW-1:0]          r_q;
  logic [CW-1:0]          r_cnt;
  logic [4:0]             r_flg_n, r_flags;

  // Operand classification on the unpacked fields.
  logic w_sq, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_a_snan, w_b_snan;
  assign w_sq     = r_sa ^ r_sb;
  assign w_a_nan  = (&r_ea) & (|r_fa);
  assign w_b_nan  = (&r_eb) & (|r_fb);
  assign w_a_inf  = (&r_ea) & ~(|r_fa);
  assign w_b_inf  = (&r_eb) & ~(|r_fb);
  assign w_a_zero = ~(|r_ea) & ~(|r_fa);
  assign w_b_zero = ~(|r_eb) & ~(|r_fb);
  assign w_a_snan = w_a_nan & ~r_fa[MAN_W-1];
  assign w_b_snan = w_b_nan & ~r_fb[MAN_W-1];

  // Subnormals take the minimum exponent with hidden bit 0; NORM_A/B then normalise them.
  logic signed [EW-1:0] w_xa0, w_xb0;
  assign w_xa0 = (r_ea == '0) ? EMIN : $signed({3'b000, r_ea}) - EBIAS;
  assign w_xb0 = (r_eb == '0) ? EMIN : $signed({3'b000, r_eb}) - EBIAS;

  logic         w_spc;
  logic [W-1:0] w_spc_res;
  logic [4:0]   w_spc_flg;
  always_comb begin
    w_spc     = 1'b1;
    w_spc_res = '0;
    w_spc_flg = '0;
    if (w_a_nan | w_b_nan) begin
      w_spc_res          = QNAN;
      w_spc_flg[FLAG_NV] = w_a_snan | w_b_snan;
    end else if ((w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
      w_spc_res          = QNAN;
      w_spc_flg[FLAG_NV] = 1'b1;
    end else if (w_a_inf) begin
      w_spc_res = {w_sq, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_b_inf | w_a_zero) begin
      w_spc_res = {w_sq, {(W-1){1'b0}}};
    end else if (w_b_zero) begin
      w_spc_res          = {w_sq, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_spc_flg[FLAG_DZ] = 1'b1;
    end else begin
      w_spc = 1'b0;
    end
  end

  // One restoring step.
  logic          w_ge;
  logic [RW-1:0] w_rsub;
  assign w_ge   = (r_rem >= {2'b00, r_mb});
  assign w_rsub = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;

  logic signed [EW-1:0] w_xq_pn, w_xq_inc;
  assign w_xq_pn  = r_q[QW-1] ? (r_xa - r_xb) : (r_xa - r_xb - EONE);
  assign w_xq_inc = r_xq + EONE;

  // Rounding on hidden+fraction; bits [2:0] of the quotient are guard, round and sticky.
  logic w_inc, w_s, w_nx, w_of, w_hid, w_inf_sel;
  logic [MAN_W+1:0]     w_sum;
  logic signed [EW-1:0] w_xr;
  logic [MAN_W-1:0]     w_man;
  logic [EXP_W-1:0]     w_efield;
  logic [W-1:0]         w_rnd_res;
  logic [4:0]           w_rnd_flg;

  assign w_s = r_q[0] | r_sticky;
  fpu_round u_round (
    .i_mode (r_rm),
    .i_sign (w_sq),
    .i_lsb  (r_q[3]),
    .i_g    (r_q[2]),
    .i_r    (r_q[1]),
    .i_s    (w_s),
    .o_inc  (w_inc)
  );

  always_comb begin
    w_sum     = {1'b0, r_q[QW-1:3]} + (MAN_W+2)'(w_inc);
    w_xr      = w_sum[MAN_W+1] ? (r_xq + EONE) : r_xq;
    w_man     = w_sum[MAN_W+1] ? '0 : w_sum[MAN_W-1:0];
    w_hid     = w_sum[MAN_W+1] | w_sum[MAN_W];
    // A result still lacking its hidden bit is subnormal and encodes exponent 0.
    w_efield  = w_hid ? EXP_W'(w_xr + EBIAS) : '0;
    w_nx      = r_q[2] | r_q[1] | w_s;
    w_of      = (w_xr > EBIAS);
    case (r_rm)
      RM_RTZ:  w_inf_sel = 1'b0;
      RM_RDN:  w_inf_sel = w_sq;
      RM_RUP:  w_inf_sel = ~w_sq;
      default: w_inf_sel = 1'b1;
    endcase
    if (!w_of)          w_rnd_res = {w_sq, w_efield, w_man};
    else if (w_inf_sel) w_rnd_res = {w_sq, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                w_rnd_res = {w_sq, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    w_rnd_flg          = '0;
    w_rnd_flg[FLAG_OF] = w_of;
    w_rnd_flg[FLAG_NX] = w_nx | w_of;
    w_rnd_flg[FLAG_UF] = r_tiny & w_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: if (i_valid) begin
          r_a     <= i_din1;
          r_b     <= i_din2;
          r_rm    <= (i_rmode > 3'd4) ? RM_RNE : rmode_e'(i_rmode);
          r_busy  <= 1'b1;
          r_state <= S_UNPACK;
        end
        S_UNPACK: begin
          r_sa    <= r_a[W-1];
          r_ea    <= r_a[W-2:MAN_W];
          r_fa    <= r_a[MAN_W-1:0];
          r_sb    <= r_b[W-1];
          r_eb    <= r_b[W-2:MAN_W];
          r_fb    <= r_b[MAN_W-1:0];
          r_state <= S_CLASSIFY;
        end
        S_CLASSIFY: if (w_spc) begin
          r_res_n <= w_spc_res;
          r_flg_n <= w_spc_flg;
          r_state <= S_PACK;
        end else begin
          r_ma    <= {|r_ea, r_fa};
          r_mb    <= {|r_eb, r_fb};
          r_xa    <= w_xa0;
          r_xb    <= w_xb0;
          r_state <= S_NORM_A;
        end
        S_NORM_A: if (r_ma[MAN_W]) r_state <= S_NORM_B;
        else begin
          r_ma <= r_ma << 1;
          r_xa <= r_xa - EONE;
        end
        S_NORM_B: if (r_mb[MAN_W]) begin
          r_rem   <= {2'b00, r_ma};
          r_q     <= '0;
          r_cnt   <= '0;
          r_state <= S_DIVIDE;
        end else begin
          r_mb <= r_mb << 1;
          r_xb <= r_xb - EONE;
        end
        S_DIVIDE: begin
          r_rem <= w_rsub << 1;
          r_q   <= {r_q[QW-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(QW - 1)) r_state <= S_POST_NORM;
        end
        S_POST_NORM: begin
          r_sticky <= |r_rem;
          r_q      <= r_q[QW-1] ? r_q : (r_q << 1);
          r_xq     <= w_xq_pn;
          r_cnt    <= '0;
          r_tiny   <= (w_xq_pn < EMIN);
          r_state  <= (w_xq_pn < EMIN) ? S_DENORM : S_ROUND;
        end
        S_DENORM: begin
          r_q      <= r_q >> 1;
          r_sticky <= r_sticky | r_q[0];
          r_cnt    <= r_cnt + 1'b1;
          // Past MAN_W+3 shifts only sticky remains, so further shifting cannot change the rounding.
          if ((w_xq_inc == EMIN) || (r_cnt == CW'(MAN_W + 2))) begin
            r_xq    <= EMIN;
            r_state <= S_ROUND;
          end else begin
            r_xq <= w_xq_inc;
          end
        end
        S_ROUND: begin
          r_res_n <= w_rnd_res;
          r_flg_n <= w_rnd_flg;
          r_state <= S_PACK;
        end
        S_PACK: begin
          r_result <= r_res_n;
          r_flags  <= r_flg_n;
          r_ready  <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_result = r_result;
  assign o_flags  = r_flags;
  assign o_ready  = r_ready;

endmodule
